// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling
// and frame-size limits used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int N_BITS_MIN = 5;
    localparam int N_BITS_MAX = 8;

    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

    // Out-of-range frame sizes fall back to a full byte.
    function automatic logic [3:0] eff_nbits(input logic [3:0] n);
        if (n >= 4'(N_BITS_MIN) && n <= 4'(N_BITS_MAX))
            return n;
        return 4'(N_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input with a
// configurable reset value.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: start/data/stop framing,
// 5..8 data bits LSB-first, glitch and break rejection.
module uart_rx #(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Rx_in,
    input  logic [3:0] N_bits,
    output logic [7:0] Data_out,
    output logic       Rx_done,
    output logic       Frame_err,
    output logic       Rx_busy
);

    import uart_pkg::*;

    generate
        if (OVERSAMPLE != 16) begin : g_bad_oversample
            $error("uart_rx supports OVERSAMPLE=16 only");
        end
    endgenerate

    logic       rx_s;
    rx_state_t  state;
    logic       arm;
    logic [3:0] tcnt;
    logic [3:0] bcnt;
    logic [3:0] nb;
    logic [7:0] shift;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (Rx_in),
        .q   (rx_s)
    );

    assign Rx_busy = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            arm       <= 1'b0;
            tcnt      <= 4'd0;
            bcnt      <= 4'd0;
            nb        <= 4'd8;
            shift     <= 8'h00;
            Data_out  <= 8'h00;
            Rx_done   <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            Rx_done   <= 1'b0;
            Frame_err <= 1'b0;
            if (Tick) begin
                unique case (state)
                    IDLE: begin
                        // A start edge only counts once the line was seen idle.
                        if (rx_s) begin
                            arm <= 1'b1;
                        end else if (arm) begin
                            state <= START;
                            tcnt  <= 4'd0;
                            nb    <= eff_nbits(N_bits);
                        end
                    end
                    START: begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == MID_START) begin
                            tcnt <= 4'd0;
                            if (!rx_s) begin
                                state <= DATA;
                                bcnt  <= 4'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == MID_BIT) begin
                            shift <= {rx_s, shift[7:1]};
                            bcnt  <= bcnt + 4'd1;
                            if (bcnt == nb - 4'd1) begin
                                state <= STOP;
                                bcnt  <= 4'd0;
                            end
                        end
                    end
                    STOP: begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == MID_BIT) begin
                            state <= IDLE;
                            tcnt  <= 4'd0;
                            if (rx_s) begin
                                Data_out <= shift >> (4'd8 - nb);
                                Rx_done  <= 1'b1;
                            end else begin
                                Frame_err <= 1'b1;
                                arm       <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, Tick pulses per bit period; the only supported value is 16.
REQ-002 Port Clock  in  1  system clock; all flops clock on its rising edge.
REQ-003 Port Reset  in  1  synchronous active-high reset, sampled on the rising edge of Clock.
REQ-004 Port Tick  in  1  one-Clock-cycle enable at OVERSAMPLE x baud, shared with the transmitter.
REQ-005 Port Rx_in  in  1  asynchronous serial line; idles high; frame is start(0), N_bits data LSB-first, stop(1).
REQ-006 Port N_bits  in  4  data bits per frame; legal values 5..8; any other value is treated as 8.
REQ-007 Port Data_out  out  8  last good frame; data in [N_bits-1:0], upper bits zero.
REQ-008 Port Rx_done  out  1  one-Clock-cycle pulse when Data_out is updated.
REQ-009 Port Frame_err  out  1  one-Clock-cycle pulse when the stop bit is sampled low.
REQ-010 Port Rx_busy  out  1  high in every state except IDLE.

Function
REQ-011 Rx_in SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses only the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; state, tick counter, bit counter and shift register SHALL advance only in cycles where Tick=1.
REQ-013 IDLE: an arm flag SHALL set on any Tick with rx_s=1; a Tick with arm=1 and rx_s=0 SHALL move to START, clear the tick counter and latch the effective N_bits.
REQ-014 START: on the Tick where the tick counter equals 7 (mid start bit), rx_s=0 SHALL move to DATA with the counter cleared; rx_s=1 SHALL return to IDLE with no outputs asserted (glitch reject).
REQ-015 DATA: on the Tick where the tick counter equals 15, the shift register SHALL load {rx_s, shift[7:1]} and the bit counter SHALL increment; after the N_bits-th sample the FSM SHALL move to STOP with the counter cleared.
REQ-016 The tick counter SHALL be 4 bits and wrap from 15 to 0 with no extra cycle.
REQ-017 STOP: on the Tick where the tick counter equals 15, rx_s=1 SHALL load Data_out with shift >> (8-N_bits) and pulse Rx_done; rx_s=0 SHALL pulse Frame_err, leave Data_out unchanged and clear arm; both cases SHALL return to IDLE.
REQ-018 Rx_done and Frame_err SHALL assert in the Clock cycle after the mid-stop Tick, SHALL last exactly one Clock cycle, and SHALL never assert together.
REQ-019 Latency from the start-bit falling edge on Rx_in to Rx_done SHALL be (N_bits+1.5) bit periods plus at most 1 Tick period plus 3 Clock cycles.
REQ-020 N_bits changes during a frame SHALL have no effect until the next start detection.
REQ-021 A line held low (break) SHALL produce exactly one Frame_err; no new frame SHALL start until rx_s is seen high (arm).
REQ-022 Data_out SHALL hold its value between frames.

Reset
REQ-023 Reset SHALL force IDLE, arm=0, counters=0, shift=0, synchronizer=1, Data_out=8'h00, Rx_done=0, Frame_err=0, Rx_busy=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and SHALL produce no Rx_done or Frame_err pulse.
REQ-025 Reset SHALL take priority over Tick in the same cycle.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE, N_BITS_MIN=5, N_BITS_MAX=8 and the mid-bit counts (7, 15), shared with the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module uart_rx_sync (2 flops, parameterized reset value); everything else SHALL be in uart_rx.

Verification
REQ-028 N_bits=8, frame 0x A5 at 16x Tick -> one Rx_done pulse, Data_out=8'hA5, Frame_err=0, Rx_busy low afterwards.
REQ-029 N_bits=5, data bits 1,0,1,1,0 -> Data_out=8'h0D, Rx_done once.
REQ-030 Rx_in low pulse lasting 4 Ticks in IDLE -> return to IDLE, no Rx_done, no Frame_err, Data_out unchanged.
REQ-031 N_bits=8, byte 0x3C with stop bit low -> Frame_err once, Data_out keeps prior value; line held low for 3 frame times -> no further pulses; line high then frame 0x55 -> Data_out=8'h55.
REQ-032 Reset pulsed after 4th data bit of 0xFF -> no pulses, Data_out=8'h00; next frame 0x81 -> Data_out=8'h81.
REQ-033 N_bits=4'd12, frame 0x96 -> treated as 8 bits, Data_out=8'h96; back-to-back frames 0x01, 0x02 with no idle gap -> two Rx_done pulses, values in order.
